// File: rtl/datapath_ctrl_pkg.sv
//------------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared types and sizes for the 32-bit bus datapath control sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package datapath_ctrl_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_IDX_W  = 4;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOADI = 2'b01,
    OP_MOV   = 2'b10,
    OP_SWAP  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LD_MDR    = 3'd1,
    ST_MDR_TO_RD = 3'd2,
    ST_MOV       = 3'd3,
    ST_SW1       = 3'd4,
    ST_SW2       = 3'd5,
    ST_SW3       = 3'd6,
    ST_DONE      = 3'd7
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_sel_decoder.sv
//------------------------------------------------------------------------------
// reg_sel_decoder
// Index-to-one-hot register select decoder with enable.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_sel_decoder
  import datapath_ctrl_pkg::*;
#(
  parameter int IDX_W   = REG_IDX_W,
  parameter int NUM_OUT = NUM_REGS
) (
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_OUT-1:0] sel
);

  always_comb begin
    sel = '0;
    if (en) sel[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/datapath_xfer_sequencer.sv
//------------------------------------------------------------------------------
// datapath_xfer_sequencer
// Accepts one register-transfer command and sequences the datapath strobes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module datapath_xfer_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_IDX_W-1:0]  cmd_rd,
  input  logic [REG_IDX_W-1:0]  cmd_rs,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  Read,
  output logic [DATA_WIDTH-1:0] Mdatain
);

  seq_state_t            state_q, state_d;
  logic [REG_IDX_W-1:0]  rd_q, rd_d;
  logic [REG_IDX_W-1:0]  rs_q, rs_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;

  logic                  rin_en, rout_en;
  logic [REG_IDX_W-1:0]  rin_idx, rout_idx;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rd_d  = cmd_rd;
          rs_d  = cmd_rs;
          imm_d = cmd_imm;
          case (op_t'(cmd_op))
            OP_NOP:   state_d = ST_DONE;
            OP_LOADI: state_d = ST_LD_MDR;
            OP_MOV:   state_d = ST_MOV;
            OP_SWAP:  state_d = ST_SW1;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LD_MDR:    state_d = ST_MDR_TO_RD;
      ST_MDR_TO_RD: state_d = ST_DONE;
      ST_MOV:       state_d = ST_DONE;
      ST_SW1:       state_d = ST_SW2;
      ST_SW2:       state_d = ST_SW3;
      ST_SW3:       state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes depend only on registered state so they hold for the whole cycle.
  always_comb begin
    rin_en   = 1'b0;
    rin_idx  = rd_q;
    rout_en  = 1'b0;
    rout_idx = rs_q;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Read     = 1'b0;
    Mdatain  = '0;
    done     = 1'b0;
    case (state_q)
      ST_LD_MDR: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Mdatain = imm_q;
      end
      ST_MDR_TO_RD: begin
        MDRout = 1'b1;
        rin_en = 1'b1;
      end
      ST_MOV: begin
        rout_en = 1'b1;
        rin_en  = 1'b1;
      end
      ST_SW1: begin
        rout_en = 1'b1;
        MDRin   = 1'b1;
      end
      ST_SW2: begin
        rout_en  = 1'b1;
        rout_idx = rd_q;
        rin_en   = 1'b1;
        rin_idx  = rs_q;
      end
      ST_SW3: begin
        MDRout = 1'b1;
        rin_en = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  reg_sel_decoder #(.IDX_W(REG_IDX_W), .NUM_OUT(NUM_REGS)) u_rin_dec (
    .en  (rin_en),
    .idx (rin_idx),
    .sel (Rin)
  );

  reg_sel_decoder #(.IDX_W(REG_IDX_W), .NUM_OUT(NUM_REGS)) u_rout_dec (
    .en  (rout_en),
    .idx (rout_idx),
    .sel (Rout)
  );

  a_one_bus_driver: assert property (@(posedge Clock) disable iff (!Clear)
    $onehot0({Rout, MDRout}));
  a_one_rin: assert property (@(posedge Clock) disable iff (!Clear)
    $onehot0(Rin));
  a_mdatain_zero: assert property (@(posedge Clock) disable iff (!Clear)
    (state_q != ST_LD_MDR) |-> (Mdatain == '0));
  a_read_only_ld: assert property (@(posedge Clock) disable iff (!Clear)
    Read |-> (state_q == ST_LD_MDR));

endmodule

`default_nettype wire
